// File: rtl/fnn_ctrl_pkg.sv
// Shared control types for the fully connected layer sequencers and the
// network-level controller.
package fnn_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } seq_state_e;

   // Cycles from an input-buffer address to its data on the neuron broadcast.
   localparam int RD_LATENCY = 1;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/layer_sequencer_out_capture.sv
// Per-neuron activation holding registers: capture on output-valid pulses,
// duplicate detection, zero-fill of missing neurons and an indexed read port.
module out_capture
   import fnn_ctrl_pkg::*;
#(
   parameter int numNeuron = 30,
   parameter int dataWidth = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           capture_en,
   input  logic [numNeuron-1:0]           pulse,
   input  logic [numNeuron*dataWidth-1:0] data_in,
   input  logic                           clr,
   input  logic                           zero_missing,
   input  logic [idx_w(numNeuron)-1:0]    rd_idx,
   output logic [dataWidth-1:0]           rd_data,
   output logic                           all_cap,
   output logic                           dup
);

   logic [numNeuron-1:0] cap;
   logic [numNeuron-1:0] hit;
   logic [dataWidth-1:0] hold [numNeuron];

   assign hit     = capture_en ? pulse : '0;
   // Same-cycle pulses count, so the sequencer can leave WAIT without a bubble.
   assign all_cap = &(cap | hit);
   assign dup     = |(cap & hit);
   assign rd_data = hold[rd_idx];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cap <= '0;
      end else begin
         cap <= cap | hit;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < numNeuron; k++) begin
         if (hit[k]) begin
            hold[k] <= data_in[k*dataWidth +: dataWidth];
         end else if (zero_missing && !cap[k]) begin
            hold[k] <= '0;
         end
      end
   end

endmodule

// File: rtl/layer_sequencer.sv
// Layer control: broadcasts the input vector to the neuron bank, collects the
// neuron activations and serializes them over a valid/ready port.
module layer_sequencer
   import fnn_ctrl_pkg::*;
#(
   parameter int numInput      = 784,
   parameter int numNeuron     = 30,
   parameter int dataWidth     = 16,
   parameter int timeoutCycles = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   output logic                           busy,
   output logic [$clog2(numInput)-1:0]    in_rd_addr,
   input  logic [dataWidth-1:0]           in_rd_data,
   output logic [dataWidth-1:0]           n_data,
   output logic                           n_valid,
   input  logic [numNeuron-1:0]           n_outvalid,
   input  logic [numNeuron*dataWidth-1:0] n_out,
   output logic [dataWidth-1:0]           o_data,
   output logic                           o_valid,
   input  logic                           o_ready,
   output logic                           o_last,
   output logic                           done,
   output logic                           err
);

   localparam int AW = $clog2(numInput);
   localparam int JW = idx_w(numNeuron);
   localparam int TW = idx_w(timeoutCycles);
   localparam logic [AW-1:0] ADDR_LAST = AW'(numInput - 1);
   localparam logic [JW-1:0] J_LAST    = JW'(numNeuron - 1);
   localparam logic [TW-1:0] T_LAST    = TW'(timeoutCycles - 1);

   seq_state_e            state;
   seq_state_e            state_nxt;
   logic [JW-1:0]         j;
   logic [TW-1:0]         tcnt;
   logic [RD_LATENCY-1:0] vld_p;
   logic                  start_ok;
   logic                  timeout;
   logic                  hs;
   logic                  last_hs;
   logic                  all_cap;
   logic                  dup;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_ok  = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (in_rd_addr == ADDR_LAST) state_nxt = WAIT;
         end
         WAIT: begin
            if (all_cap) begin
               state_nxt = DRAIN;
            end else if (tcnt == T_LAST) begin
               timeout   = 1'b1;
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (last_hs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign o_valid = (state == DRAIN);
   assign o_last  = o_valid && (j == J_LAST);
   assign hs      = o_valid && o_ready;
   assign last_hs = hs && o_last;
   assign n_data  = in_rd_data;
   assign n_valid = vld_p[RD_LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         in_rd_addr <= '0;
         tcnt       <= '0;
         j          <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         vld_p      <= '0;
      end else begin
         done  <= last_hs;
         // Broadcast valid trails the issued address by the buffer read latency.
         vld_p <= RD_LATENCY'({vld_p, (state == FETCH)});
         if (start_ok) begin
            in_rd_addr <= '0;
         end else if (state == FETCH && in_rd_addr != ADDR_LAST) begin
            in_rd_addr <= in_rd_addr + 1'b1;
         end
         tcnt <= (state == WAIT) ? tcnt + 1'b1 : '0;
         if (hs) j <= last_hs ? '0 : j + 1'b1;
         if (start_ok) begin
            err <= 1'b0;
         end else if (dup || timeout) begin
            err <= 1'b1;
         end
      end
   end

   out_capture #(
      .numNeuron (numNeuron),
      .dataWidth (dataWidth)
   ) u_capture (
      .clk          (clk),
      .rst          (rst),
      .capture_en   (busy),
      .pulse        (n_outvalid),
      .data_in      (n_out),
      .clr          (last_hs),
      .zero_missing (timeout),
      .rd_idx       (j),
      .rd_data      (o_data),
      .all_cap      (all_cap),
      .dup          (dup)
   );

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed and random passes against a cycle-level
// reference derived from the sequencing rules.
module tb_layer_sequencer;

   localparam int NI = 4;
   localparam int NN = 3;
   localparam int DW = 16;
   localparam int TO = 8;
   localparam int W  = NI + 1;
   localparam int NW = NN * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic [1:0]    in_rd_addr;
   logic [DW-1:0] in_rd_data;
   logic [DW-1:0] n_data;
   logic          n_valid;
   logic [NN-1:0] n_outvalid;
   logic [NW-1:0] n_out;
   logic [DW-1:0] o_data;
   logic          o_valid;
   logic          o_ready;
   logic          o_last;
   logic          done;
   logic          err;

   logic [DW-1:0] mem [NI];
   int            pcyc [$];
   int            pnrn [$];
   logic [DW-1:0] pval [$];
   int            rdy_mode;
   int            rdy_pat [$];
   int            n_chk = 0;
   int            n_bad = 0;
   logic          err_prev;

   always #5 clk = ~clk;

   always @(posedge clk) in_rd_data <= mem[in_rd_addr];

   layer_sequencer #(
      .numInput      (NI),
      .numNeuron     (NN),
      .dataWidth     (DW),
      .timeoutCycles (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .in_rd_addr (in_rd_addr),
      .in_rd_data (in_rd_data),
      .n_data     (n_data),
      .n_valid    (n_valid),
      .n_outvalid (n_outvalid),
      .n_out      (n_out),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_ready    (o_ready),
      .o_last     (o_last),
      .done       (done),
      .err        (err)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_vals();
      check_val("rst_busy", busy, 0);
      check_val("rst_addr", in_rd_addr, 0);
      check_val("rst_n_valid", n_valid, 0);
      check_val("rst_o_valid", o_valid, 0);
      check_val("rst_o_last", o_last, 0);
      check_val("rst_done", done, 0);
      check_val("rst_err", err, 0);
      check_val("rst_n_data", n_data, in_rd_data);
   endtask

   task automatic clear_sched();
      pcyc.delete();
      pnrn.delete();
      pval.delete();
   endtask

   task automatic add_pulse(input int k, input int c, input logic [DW-1:0] v);
      pcyc.push_back(c);
      pnrn.push_back(k);
      pval.push_back(v);
   endtask

   task automatic gen_random();
      int c;
      int c2;
      foreach (mem[i]) mem[i] = DW'($urandom());
      clear_sched();
      for (int k = 0; k < NN; k++) begin
         if ($urandom_range(0, 5) == 0) continue;
         c = $urandom_range(3, W + TO - 2);
         add_pulse(k, c, DW'($urandom()));
         if ($urandom_range(0, 4) == 0) begin
            c2 = $urandom_range(3, W + TO + 2);
            if (c2 != c) add_pulse(k, c2, DW'($urandom()));
         end
      end
      rdy_mode = 2;
   endtask

   // One start-to-done pass; cycle 0 is the start cycle. With b2b the start
   // is raised in the previous pass's done cycle.
   task automatic run_pass(input bit b2b);
      int            first [NN];
      int            lastc [NN];
      logic [DW-1:0] exp_hold [NN];
      int            kc [$];
      int            kn [$];
      logic [DW-1:0] kv [$];
      int            c_all;
      int            d;
      int            first_dup;
      int            done_cyc;
      int            jm;
      bit            missing;
      bit            tmo;
      bit            in_drain;
      bit            exp_err;
      bit            exp_nv;
      bit            finished;
      c_all = 0; missing = 0; first_dup = -1; done_cyc = -1; jm = 0; finished = 0;
      for (int k = 0; k < NN; k++) begin
         first[k] = -1; lastc[k] = -1; exp_hold[k] = '0;
      end
      foreach (pcyc[i])
         if (first[pnrn[i]] < 0 || pcyc[i] < first[pnrn[i]]) first[pnrn[i]] = pcyc[i];
      for (int k = 0; k < NN; k++) begin
         if (first[k] < 0) missing = 1;
         else if (first[k] > c_all) c_all = first[k];
      end
      // DRAIN begins the cycle after everything is captured, or after TO WAIT cycles.
      if (missing) begin
         d = W + TO;
      end else begin
         d = (c_all > W) ? c_all : W;
         if (d > W + TO - 1) d = W + TO - 1;
         d = d + 1;
      end
      tmo = missing || (c_all > W + TO - 1);
      foreach (pcyc[i]) begin
         if (pcyc[i] < d) begin
            kc.push_back(pcyc[i]); kn.push_back(pnrn[i]); kv.push_back(pval[i]);
            if (pcyc[i] != first[pnrn[i]] && (first_dup < 0 || pcyc[i] < first_dup))
               first_dup = pcyc[i];
            if (pcyc[i] > lastc[pnrn[i]]) begin
               lastc[pnrn[i]] = pcyc[i];
               exp_hold[pnrn[i]] = pval[i];
            end
         end
      end

      for (int t = 0; t <= 200; t++) begin
         if (t > 0 || !b2b) begin
            @(posedge clk); #1;
         end
         start = (t == 0) || ((done_cyc < 0 || t < done_cyc) && $urandom_range(0, 7) == 0);
         n_outvalid = '0;
         n_out = NW'({$urandom(), $urandom()});
         foreach (kc[i]) begin
            if (kc[i] == t) begin
               n_outvalid[kn[i]] = 1'b1;
               n_out[kn[i]*DW +: DW] = kv[i];
            end
         end
         case (rdy_mode)
            0: o_ready = 1'b1;
            1: o_ready = (t >= d && rdy_pat.size() > 0) ? (rdy_pat.pop_front() != 0) : 1'b1;
            default: o_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (t == 0 && b2b) continue;
         @(negedge clk);
         in_drain = (t >= d) && (done_cyc < 0);
         if (t == 0) begin
            check_val("idle_busy", busy, 0);
            check_val("idle_err", err, err_prev);
         end else begin
            exp_err = (first_dup >= 0 && t > first_dup) || (tmo && t >= d);
            exp_nv  = (t >= 2 && t <= NI + 1);
            check_val("busy", busy, (done_cyc < 0 || t < done_cyc));
            check_val("done", done, (t == done_cyc));
            check_val("err", err, exp_err);
            check_val("n_valid", n_valid, exp_nv);
            if (exp_nv) check_val("n_data", n_data, mem[t-2]);
            if (t <= NI) check_val("rd_addr", in_rd_addr, t - 1);
            check_val("o_valid", o_valid, in_drain);
            if (in_drain) begin
               check_val("o_data", o_data, exp_hold[jm]);
               check_val("o_last", o_last, (jm == NN - 1));
               if (o_ready) begin
                  if (jm == NN - 1) done_cyc = t + 1;
                  else jm++;
               end
            end else begin
               check_val("o_last_idle", o_last, 0);
            end
            if (t == done_cyc) begin
               err_prev = exp_err;
               finished = 1;
               break;
            end
         end
      end
      check_val("pass_end", finished, 1);
   endtask

   task automatic reset_midpass();
      for (int t = 0; t <= 4; t++) begin
         @(posedge clk); #1;
         start      = (t == 0) || (t == 2);
         n_outvalid = (t == 1 || t == 2) ? 3'b001 : 3'b000;
         n_out      = NW'(t * 16'h0101);
         o_ready    = 1'b1;
         rst        = (t == 3);
         @(negedge clk);
         if (t == 3) begin
            check_val("mid_busy", busy, 1);
            check_val("mid_err", err, 1);
         end
         if (t == 4) check_reset_vals();
      end
      err_prev = 1'b0;
   endtask

   task automatic sched_basic();
      clear_sched();
      add_pulse(0, 7, 16'h0011);
      add_pulse(1, 8, 16'h0022);
      add_pulse(2, 8, 16'h0033);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; n_outvalid = '0; n_out = '0; o_ready = 1'b1;
      err_prev = 1'b0; rdy_mode = 0;
      for (int i = 0; i < NI; i++) mem[i] = DW'((i + 1) * 16'h0100);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals();
      @(posedge clk); #1;
      rst = 1'b0;

      sched_basic();
      rdy_mode = 0;
      run_pass(0);

      rdy_pat = '{1, 0, 0, 1, 1};
      rdy_mode = 1;
      run_pass(1);

      clear_sched();
      add_pulse(0, 7, 16'h0011);
      add_pulse(1, 8, 16'h0022);
      rdy_mode = 0;
      run_pass(0);

      clear_sched();
      add_pulse(0, 6, 16'hAAAA);
      add_pulse(0, 7, 16'h0011);
      add_pulse(1, 7, 16'h0022);
      add_pulse(2, 7, 16'h0033);
      run_pass(0);

      reset_midpass();
      sched_basic();
      rdy_mode = 0;
      run_pass(0);

      for (int p = 0; p < 25; p++) begin
         gen_random();
         run_pass($urandom_range(0, 1) == 1);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1);
   end

endmodule
